mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_DM_RUN, default 4, the maximum consecutive data grants while a fetch waits (range 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 16, the cycles allowed for mem_ready per transaction (used only with ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port if_req, input, 1, instruction-fetch request; held until if_done.
REQ-006 SHALL have port if_addr, input, 32, fetch address; stable while if_req is high.
REQ-007 SHALL have port dm_req, input, 1, data-memory request; held until dm_done.
REQ-008 SHALL have ports dm_addr (32), dm_we (1) and dm_wdata (32), inputs, data address, write enable and write data; stable while dm_req is high.
REQ-009 SHALL have port mem_ready, input, 1, memory completion strobe for the current access.
REQ-010 SHALL have port mem_valid, output, 1, access in progress on the shared port.
REQ-011 SHALL have ports mem_addr (32), mem_we (1) and mem_wdata (32), outputs, shared-port address, write enable and write data.
REQ-012 SHALL have port sel, output, 1, registered owner select; 0 = fetch, 1 = data.
REQ-013 SHALL have ports if_done and dm_done, outputs, 1 each, one-cycle completion pulses.
REQ-014 SHALL have port err, output, 1, timeout-abort pulse (tied 0 without ARB_TIMEOUT_EN).

Function
REQ-015 SHALL implement states IDLE, BUSY_IF and BUSY_DM.
REQ-016 In IDLE: dm_req only -> BUSY_DM; if_req only -> BUSY_IF; neither -> stay IDLE.
REQ-017 In IDLE with both requests: BUSY_DM if dm_run < MAX_DM_RUN, else BUSY_IF.
REQ-018 dm_run (4-bit) SHALL increment on each BUSY_DM entry with if_req high, clear on BUSY_IF entry or on BUSY_DM entry with if_req low, and saturate at MAX_DM_RUN.
REQ-019 sel SHALL be registered on the transition out of IDLE and hold for the whole transaction.
REQ-020 mem_addr SHALL be if_addr when sel=0 and dm_addr when sel=1, as a combinational 32-bit 2:1 select.
REQ-021 mem_wdata SHALL equal dm_wdata, and mem_we SHALL equal dm_we in BUSY_DM and 0 otherwise.
REQ-022 mem_valid SHALL be 1 exactly while in BUSY_IF or BUSY_DM.
REQ-023 Latency: a request seen in IDLE at edge N SHALL give mem_valid=1 from cycle N+1.
REQ-024 On mem_ready=1 in BUSY_x: pulse x_done combinationally in that cycle, then return to IDLE at the next edge.
REQ-025 The minimum back-to-back spacing SHALL be one IDLE cycle between transactions.
REQ-026 mem_ready in IDLE SHALL be ignored.
REQ-027 A request dropped mid-transaction SHALL be ignored; the transaction still completes and pulses done.
REQ-028 if_done and dm_done SHALL never be high in the same cycle.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, sel=0, dm_run=0 and the timeout counter to 0; mem_valid, mem_we, if_done, dm_done and err SHALL be 0.
REQ-030 Reset mid-transaction SHALL abort it with no done pulse; arbitration resumes on the first edge after rst falls.

Configuration
REQ-031 With macro ARB_TIMEOUT_EN defined: a counter SHALL clear on BUSY entry and increment each BUSY cycle without mem_ready.
REQ-032 With ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT-1 without mem_ready: pulse err for 1 cycle, give no done pulse, and return to IDLE.
REQ-033 With ARB_TIMEOUT_EN defined, mem_ready arriving in the same cycle as the timeout SHALL win: done pulses and err stays 0.
REQ-034 Without ARB_TIMEOUT_EN: no counter, err tied 0, and BUSY waits indefinitely for mem_ready.

Verification
REQ-035 Fetch only: if_req=1, if_addr=0x100, mem_ready 2 cycles after mem_valid -> sel=0, mem_addr=0x100, mem_we=0, if_done pulses once.
REQ-036 Simultaneous requests, dm_addr=0x2000, if_addr=0x40 -> DM granted first, mem_addr=0x2000, sel=1, dm_done, then the fetch is served.
REQ-037 Starvation: both requests held continuously, mem_ready=1 every busy cycle -> grants DM,DM,DM,DM,IF with default MAX_DM_RUN=4, then the pattern repeats.
REQ-038 Write: dm_we=1, dm_wdata=0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF only while in BUSY_DM.
REQ-039 Assert rst during BUSY_DM -> mem_valid=0 asynchronously, no dm_done; after release with dm_req still high, re-grant next edge.
REQ-040 ARB_TIMEOUT_EN, TIMEOUT=16, mem_ready held 0 -> err pulses in the 16th busy cycle, then IDLE; with mem_ready=1 in that same cycle, dm_done pulses and err=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and data accesses.
// Optional macro ARB_TIMEOUT_EN adds a per-transaction mem_ready timeout with an err pulse.

module mem_port_arbiter #(
  parameter int MAX_DM_RUN = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  input  logic        dm_we,
  input  logic [31:0] dm_wdata,
  input  logic        mem_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        sel,
  output logic        if_done,
  output logic        dm_done,
  output logic        err
);

  // state   | meaning
  // IDLE    | port free, arbitrate on this edge
  // BUSY_IF | fetch owns the port, waiting for mem_ready
  // BUSY_DM | data access owns the port, waiting for mem_ready
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  localparam logic [3:0] MAX_RUN = 4'(MAX_DM_RUN);

  if (MAX_DM_RUN < 1 || MAX_DM_RUN > 15) begin : g_bad_run
    $error("MAX_DM_RUN out of range");
  end
  if (TIMEOUT < 2) begin : g_bad_tmo
    $error("TIMEOUT must be at least 2");
  end

  state_t     state_q;
  logic       sel_q;
  logic [3:0] dm_run_q;
  logic [3:0] dm_run_d;
  logic       grant_dm;
  logic       busy;

  // Data keeps priority until it has won MAX_DM_RUN times in a row over a waiting fetch.
  assign grant_dm = dm_req && (!if_req || (dm_run_q < MAX_RUN));
  assign dm_run_d = !if_req ? 4'd0 :
                    (dm_run_q >= MAX_RUN) ? MAX_RUN : dm_run_q + 4'd1;
  assign busy     = (state_q != IDLE);

`ifdef ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmo_q;
  logic          tmo_hit;

  assign tmo_hit = busy && !mem_ready && (tmo_q == TW'(TIMEOUT - 1));
  assign err     = tmo_hit;
`else
  logic tmo_hit;

  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      dm_run_q <= 4'd0;
`ifdef ARB_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_dm) begin
            state_q  <= BUSY_DM;
            sel_q    <= 1'b1;
            dm_run_q <= dm_run_d;
`ifdef ARB_TIMEOUT_EN
            tmo_q    <= '0;
`endif
          end else if (if_req) begin
            state_q  <= BUSY_IF;
            sel_q    <= 1'b0;
            dm_run_q <= 4'd0;
`ifdef ARB_TIMEOUT_EN
            tmo_q    <= '0;
`endif
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (mem_ready || tmo_hit) begin
            state_q <= IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel       = sel_q;
  assign mem_valid = busy;
  assign mem_addr  = sel_q ? dm_addr : if_addr;
  assign mem_wdata = dm_wdata;
  assign mem_we    = (state_q == BUSY_DM) ? dm_we : 1'b0;
  // mem_ready outranks a same-cycle timeout, so done is never suppressed by err.
  assign if_done   = (state_q == BUSY_IF) && mem_ready;
  assign dm_done   = (state_q == BUSY_DM) && mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter; inputs change and outputs are checked on the falling edge.

module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic        dm_we;
  logic [31:0] dm_wdata;
  logic        mem_ready;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        sel;
  logic        if_done;
  logic        dm_done;
  logic        err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.MAX_DM_RUN(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata),
    .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .sel(sel), .if_done(if_done), .dm_done(dm_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_addr = 0;
    dm_we = 0; dm_wdata = 0; mem_ready = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_valid, sel, mem_we, if_done, dm_done, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid/sel/we/ifd/dmd/err=%b expected 000000",
               {mem_valid, sel, mem_we, if_done, dm_done, err});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: mem_valid=%b expected 0", mem_valid);
    end
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 32'h100;
    @(negedge clk);
    checks++;
    if ({mem_valid, sel, mem_we, if_done} !== 4'b1000 || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL fetch_grant: valid/sel/we/done=%b addr=%h expected 1000 addr=00000100",
               {mem_valid, sel, mem_we, if_done}, mem_addr);
    end
    @(negedge clk);
    mem_ready = 1; #1;
    checks++;
    if (if_done !== 1'b1 || dm_done !== 1'b0) begin
      errors++; $display("FAIL fetch_done: if_done=%b dm_done=%b expected 1 0", if_done, dm_done);
    end
    @(negedge clk);
    if_req = 0; mem_ready = 0; #1;
    checks++;
    if (mem_valid !== 1'b0 || if_done !== 1'b0) begin
      errors++; $display("FAIL fetch_release: valid=%b if_done=%b expected 0 0", mem_valid, if_done);
    end
  endtask

  task automatic test_simultaneous();
    if_req = 1; if_addr = 32'h40; dm_req = 1; dm_addr = 32'h2000; dm_we = 0;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1 || sel !== 1'b1 || mem_addr !== 32'h2000) begin
      errors++;
      $display("FAIL simul_dm_first: valid=%b sel=%b addr=%h expected 1 1 00002000", mem_valid, sel, mem_addr);
    end
    mem_ready = 1; #1;
    checks++;
    if (dm_done !== 1'b1 || if_done !== 1'b0) begin
      errors++; $display("FAIL simul_dm_done: dm_done=%b if_done=%b expected 1 0", dm_done, if_done);
    end
    @(negedge clk);
    dm_req = 0; mem_ready = 0;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1 || sel !== 1'b0 || mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL simul_if_second: valid=%b sel=%b addr=%h expected 1 0 00000040", mem_valid, sel, mem_addr);
    end
    mem_ready = 1; #1;
    checks++;
    if (if_done !== 1'b1 || dm_done !== 1'b0) begin
      errors++; $display("FAIL simul_if_done: if_done=%b dm_done=%b expected 1 0", if_done, dm_done);
    end
    @(negedge clk);
    if_req = 0; mem_ready = 0;
  endtask

  task automatic test_starvation();
    logic [9:0] exp_sel;
    exp_sel = 10'b0111101111;  // bit i = owner of grant i: DM,DM,DM,DM,IF repeated
    if_req = 1; if_addr = 32'h80; dm_req = 1; dm_addr = 32'h5000; mem_ready = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'b1 || sel !== exp_sel[i] || if_done !== ~exp_sel[i] || dm_done !== exp_sel[i]) begin
        errors++;
        $display("FAIL starve_grant%0d: valid=%b sel=%b ifd=%b dmd=%b expected sel=%b",
                 i, mem_valid, sel, if_done, dm_done, exp_sel[i]);
      end
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'b0 || if_done !== 1'b0 || dm_done !== 1'b0) begin
        errors++;
        $display("FAIL starve_idle%0d: valid=%b ifd=%b dmd=%b expected 0 0 0", i, mem_valid, if_done, dm_done);
      end
    end
    if_req = 0; dm_req = 0; mem_ready = 0;
    @(negedge clk);
  endtask

  task automatic test_write();
    dm_req = 1; dm_we = 1; dm_wdata = 32'hDEADBEEF; dm_addr = 32'h3000; #1;
    checks++;
    if (mem_we !== 1'b0) begin
      errors++; $display("FAIL write_we_idle: mem_we=%b expected 0", mem_we);
    end
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h3000 || sel !== 1'b1) begin
      errors++;
      $display("FAIL write_busy: we=%b wdata=%h addr=%h sel=%b expected 1 deadbeef 00003000 1",
               mem_we, mem_wdata, mem_addr, sel);
    end
    mem_ready = 1; #1;
    checks++;
    if (dm_done !== 1'b1) begin
      errors++; $display("FAIL write_done: dm_done=%b expected 1", dm_done);
    end
    @(negedge clk);
    dm_req = 0; mem_ready = 0; #1;
    checks++;
    if (mem_we !== 1'b0 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL write_we_after: we=%b valid=%b expected 0 0", mem_we, mem_valid);
    end
    dm_we = 0;
  endtask

  task automatic test_drop_mid();
    if_req = 1; if_addr = 32'h200;
    @(negedge clk);
    if_req = 0;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1 || sel !== 1'b0) begin
      errors++; $display("FAIL drop_still_busy: valid=%b sel=%b expected 1 0", mem_valid, sel);
    end
    mem_ready = 1; #1;
    checks++;
    if (if_done !== 1'b1) begin
      errors++; $display("FAIL drop_done: if_done=%b expected 1", if_done);
    end
    @(negedge clk);
    mem_ready = 0;
  endtask

  task automatic test_reset_mid();
    dm_req = 1; dm_addr = 32'h4000;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_busy: valid=%b expected 1", mem_valid);
    end
    mem_ready = 1; #1;
    rst = 1; #1;
    checks++;
    if (mem_valid !== 1'b0 || dm_done !== 1'b0 || sel !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: valid=%b dm_done=%b sel=%b expected 0 0 0", mem_valid, dm_done, sel);
    end
    @(negedge clk);
    rst = 0; mem_ready = 0;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1 || sel !== 1'b1 || mem_addr !== 32'h4000) begin
      errors++;
      $display("FAIL rstmid_regrant: valid=%b sel=%b addr=%h expected 1 1 00004000", mem_valid, sel, mem_addr);
    end
    mem_ready = 1;
    @(negedge clk);
    dm_req = 0; mem_ready = 0;
    @(negedge clk);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int bad;
    bad = 0;
    dm_req = 1; dm_addr = 32'h6000; mem_ready = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (err !== 1'b0 || mem_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL tmo_early: %0d busy cycles wrong before cycle 16, expected 0", bad);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || dm_done !== 1'b0) begin
      errors++; $display("FAIL tmo_err: err=%b dm_done=%b expected 1 0", err, dm_done);
    end
    @(negedge clk);
    dm_req = 0; #1;
    checks++;
    if (mem_valid !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL tmo_idle: valid=%b err=%b expected 0 0", mem_valid, err);
    end
    @(negedge clk);
    dm_req = 1;
    repeat (16) @(negedge clk);
    mem_ready = 1; #1;
    checks++;
    if (dm_done !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL tmo_ready_wins: dm_done=%b err=%b expected 1 0", dm_done, err);
    end
    @(negedge clk);
    dm_req = 0; mem_ready = 0;
    @(negedge clk);
  endtask
`else
  task automatic test_no_timeout();
    int bad;
    bad = 0;
    dm_req = 1; dm_addr = 32'h6000; mem_ready = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (err !== 1'b0 || mem_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL notmo_wait: %0d cycles with err or idle, expected 0", bad);
    end
    mem_ready = 1; #1;
    checks++;
    if (dm_done !== 1'b1) begin
      errors++; $display("FAIL notmo_done: dm_done=%b expected 1", dm_done);
    end
    @(negedge clk);
    dm_req = 0; mem_ready = 0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_starvation();
    test_write();
    test_drop_mid();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
